// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: load-use stalls, branch/jump flushes, memory-wait freeze, halt.
// Latency: all enables/flushes are combinational (Mealy) from the current inputs and state; counters update on the next edge.
// Backpressure: a memory access freezes every stage for MEM_WAIT_CYC cycles; halt_req freezes until released.
//
// Ports:
//   clk, arst_n                    clock, asynchronous active-low reset
//   id_rs1, id_rs2, id_uses_rs2    source operands of the instruction in IF/ID
//   ex_memread, ex_rd              load flag and destination held in ID/EX
//   mem_branch/zero/jump           control-transfer flags held in EX/MEM
//   mem_memread, mem_memwrite      data-memory access flags held in EX/MEM
//   halt_req                       level request to halt the pipeline
//   *_en, *_flush, pc_redirect     pipeline register controls
//   state                          RUN=0, WAIT=1, HALT=2
//   stall_cnt, flush_cnt           saturating performance counters
module pipeline_hazard_ctrl #(
    parameter int MEM_WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        mem_branch,
    input  logic        mem_zero,
    input  logic        mem_jump,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    input  logic        halt_req,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        pc_redirect,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    // Counter only has to hold MEM_WAIT_CYC-1.
    localparam int CW = (MEM_WAIT_CYC > 2) ? $clog2(MEM_WAIT_CYC) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = (MEM_WAIT_CYC > 0) ? CW'(MEM_WAIT_CYC - 1) : '0;
    localparam bit HAS_WAIT = (MEM_WAIT_CYC != 0);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t        cur_st, nxt_st;
    logic [CW-1:0] cyc_cnt, cyc_cnt_nxt;

    logic taken, lu, macc;
    logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
    logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c, pc_redirect_c;
    logic stall_inc, flush_inc;

    assign taken = (mem_branch & mem_zero) | mem_jump;
    assign lu    = ex_memread & (ex_rd != 5'd0) &
                   ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    assign macc  = (mem_memread | mem_memwrite) & HAS_WAIT;

    always_comb begin
        pc_en_c        = 1'b1;
        if_id_en_c     = 1'b1;
        id_ex_en_c     = 1'b1;
        ex_mem_en_c    = 1'b1;
        mem_wb_en_c    = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        pc_redirect_c  = 1'b0;
        nxt_st         = cur_st;
        cyc_cnt_nxt    = cyc_cnt;
        flush_inc      = 1'b0;

        unique case (cur_st)
            ST_HALT: begin
                if (halt_req) begin
                    {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c} = '0;
                end else begin
                    nxt_st = ST_RUN;
                end
            end
            default: begin
                if (cur_st == ST_WAIT && cyc_cnt != '0) begin
                    {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c} = '0;
                    cyc_cnt_nxt = cyc_cnt - CW'(1);
                end else begin
                    // RUN, or the WAIT release cycle (which ignores macc and halt_req).
                    nxt_st = ST_RUN;
                    if (taken) begin
                        // A taken transfer squashes the load-use victim anyway, so no stall.
                        if_id_flush_c  = 1'b1;
                        id_ex_flush_c  = 1'b1;
                        ex_mem_flush_c = 1'b1;
                        pc_redirect_c  = 1'b1;
                        flush_inc      = 1'b1;
                    end else if (cur_st == ST_RUN && macc) begin
                        {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c} = '0;
                        cyc_cnt_nxt = WAIT_LOAD;
                        nxt_st      = ST_WAIT;
                    end else if (cur_st == ST_RUN && halt_req) begin
                        {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c} = '0;
                        nxt_st = ST_HALT;
                    end else if (lu) begin
                        pc_en_c       = 1'b0;
                        if_id_en_c    = 1'b0;
                        id_ex_flush_c = 1'b1;
                    end
                end
            end
        endcase

        // The cycle that enters HALT is attributed to the halt, not counted as a stall.
        stall_inc = ~pc_en_c & (cur_st != ST_HALT) & (nxt_st != ST_HALT);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cur_st    <= ST_RUN;
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            cur_st  <= nxt_st;
            cyc_cnt <= cyc_cnt_nxt;
            if (stall_inc && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_inc && flush_cnt != 32'hFFFF_FFFF) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    // Reset forces every control low without waiting for a clock edge.
    assign pc_en        = arst_n & pc_en_c;
    assign if_id_en     = arst_n & if_id_en_c;
    assign id_ex_en     = arst_n & id_ex_en_c;
    assign ex_mem_en    = arst_n & ex_mem_en_c;
    assign mem_wb_en    = arst_n & mem_wb_en_c;
    assign if_id_flush  = arst_n & if_id_flush_c;
    assign id_ex_flush  = arst_n & id_ex_flush_c;
    assign ex_mem_flush = arst_n & ex_mem_flush_c;
    assign pc_redirect  = arst_n & pc_redirect_c;
    assign state        = cur_st;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios then randomized traffic vs a reference model.
// Latency: controls checked combinationally each cycle; counters/state checked after each edge.
// Backpressure: model tracks remaining freeze cycles and halt mode.
module tb_pipeline_hazard_ctrl;

    localparam int MWC = 3;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs2, ex_memread;
    logic        mem_branch, mem_zero, mem_jump, mem_memread, mem_memwrite, halt_req;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_WAIT_CYC(MWC)) dut (
        .clk(clk), .arst_n(arst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .halt_req(halt_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .pc_redirect(pc_redirect), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0=running, 1=memory wait, 2=halted; freeze_left = frozen cycles still owed in wait.
    int          m_mode;
    int          m_left;
    logic [31:0] m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] ctl_vec();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_left  = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; ex_memread = 0; ex_rd = 0;
        mem_branch = 0; mem_zero = 0; mem_jump = 0;
        mem_memread = 0; mem_memwrite = 0; halt_req = 0;
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic step();
        bit tk, lu, macc, frz, lu_stall, fl, rel;
        int nm, nl;
        logic [8:0] ev;
        #1;
        tk   = (mem_branch && mem_zero) || mem_jump;
        lu   = ex_memread && ex_rd != 0 &&
               (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
        macc = (mem_memread || mem_memwrite) && MWC != 0;
        frz = 0; lu_stall = 0; fl = 0;
        nm = m_mode; nl = m_left;
        if (m_mode == 2) begin
            if (halt_req) frz = 1;
            else nm = 0;
        end else if (m_mode == 1 && m_left > 0) begin
            frz = 1;
            nl  = m_left - 1;
        end else begin
            rel = (m_mode == 1);
            nm  = 0;
            if (tk) fl = 1;
            else if (!rel && macc) begin frz = 1; nm = 1; nl = MWC - 1; end
            else if (!rel && halt_req) begin frz = 1; nm = 2; end
            else if (lu) lu_stall = 1;
        end
        if (frz)           ev = 9'b00000_0000;
        else if (fl)       ev = 9'b11111_1111;
        else if (lu_stall) ev = 9'b00111_0100;
        else               ev = 9'b11111_0000;
        chk("ctl", {23'd0, ctl_vec()}, {23'd0, ev});
        chk("state", {30'd0, state}, m_mode);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        @(posedge clk);
        if (((frz && m_mode != 2 && nm != 2) || lu_stall) && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (fl && m_flush != 32'hFFFF_FFFF) m_flush++;
        m_mode = nm;
        m_left = nl;
        #1;
    endtask

    logic [31:0] s0, f0;

    initial begin
        idle();
        arst_n = 1'b0;
        model_reset();
        #2;
        chk("rst_ctl", {23'd0, ctl_vec()}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_flush", flush_cnt, 32'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        step();

        // Load-use, then the same pattern with rd = x0.
        ex_memread = 1; ex_rd = 5; id_rs1 = 5;
        step();
        idle(); step();
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        ex_memread = 1; ex_rd = 0; id_rs1 = 0;
        step();
        idle(); step();
        chk("lu_x0_stall_cnt", stall_cnt, 32'd1);

        // Branch taken, then branch not taken.
        mem_branch = 1; mem_zero = 1;
        step();
        idle(); step();
        chk("br_flush_cnt", flush_cnt, 32'd1);
        mem_branch = 1; mem_zero = 0;
        step();
        idle(); step();
        chk("br_nt_flush_cnt", flush_cnt, 32'd1);

        // Memory wait with the access held through the release cycle.
        s0 = stall_cnt;
        mem_memread = 1;
        repeat (4) step();
        idle(); step();
        chk("mw_stall_delta", stall_cnt - s0, 32'd3);

        // Coincident load-use and jump: flush only.
        s0 = stall_cnt; f0 = flush_cnt;
        ex_memread = 1; ex_rd = 5; id_rs1 = 5; mem_jump = 1;
        step();
        idle(); step();
        chk("co_stall_delta", stall_cnt - s0, 32'd0);
        chk("co_flush_delta", flush_cnt - f0, 32'd1);

        // Halt requested during a memory wait is deferred.
        s0 = stall_cnt;
        mem_memwrite = 1;
        step();
        mem_memwrite = 0; halt_req = 1;
        repeat (3) step();
        chk("halt_state", {30'd0, state}, 32'd0);
        repeat (3) step();
        chk("halt_in_halt", {30'd0, state}, 32'd2);
        halt_req = 0;
        step();
        step();
        chk("halt_stall_delta", stall_cnt - s0, 32'd3);

        // Reset asserted in the middle of a wait.
        mem_memread = 1;
        step();
        idle();
        #2;
        arst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_ctl", {23'd0, ctl_vec()}, 32'd0);
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_stall", stall_cnt, 32'd0);
        chk("arst_flush", flush_cnt, 32'd0);
        #2;
        arst_n = 1'b1;
        step();
        chk("post_rst_ctl", {23'd0, ctl_vec()}, 32'h1F0);

        // Randomized traffic with small register ranges so hazards collide often.
        for (int i = 0; i < 3000; i++) begin
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            ex_memread   = ($urandom_range(0, 2) == 0);
            ex_rd        = 5'($urandom_range(0, 3));
            mem_branch   = ($urandom_range(0, 4) == 0);
            mem_zero     = 1'($urandom_range(0, 1));
            mem_jump     = ($urandom_range(0, 12) == 0);
            mem_memread  = ($urandom_range(0, 7) == 0);
            mem_memwrite = ($urandom_range(0, 9) == 0);
            halt_req     = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
